// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: ALU opcodes, flag bit positions and the default
// datapath width used by the Z-stage ALU and its multiply sequencer.
package cpu_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;
  localparam logic [3:0] ALU_ASR  = 4'd8;
  localparam logic [3:0] ALU_INC  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] make_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial-product step per clock, WIDTH steps per product.
// o_fin/o_product are valid combinationally on the final step edge so the owner can latch them.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_fin,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done;

  logic [WIDTH:0]     w_hi_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;

  // NOTE: every variable gets a default before any condition, so no latch is inferred.
  always_comb begin
    w_hi_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    if (r_acc[0]) begin
      w_hi_sum = w_hi_sum + {1'b0, r_mcand};
    end
    w_acc_next = {w_hi_sum, r_acc[WIDTH-1:1]};
  end

  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  // NOTE: flops update with non-blocking (<=) so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mcand <= i_mcand;
            r_acc   <= {{WIDTH{1'b0}}, i_mplier};
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = (r_state == S_RUN);
  assign o_done    = r_done;
  assign o_fin     = w_last;
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_z.sv
// Z-stage ALU of the single-bus CPU: combines Y (operand A) with the DATA bus (operand B),
// latches result and {N,Z,C,V} into Z, and drives Z back onto DATA on request.
module alu_z
  import cpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] Y_IN,
  input  logic [3:0]       ALU_OP,
  input  logic             Z_in,
  input  logic             Z_out,
  output logic [WIDTH-1:0] REG_OUT_Z,
  output logic [3:0]       FLAGS,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0]   r_z;
  logic [3:0]         r_flags;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;
  logic               w_busy;
  logic               w_mul_fin;
  logic [2*WIDTH-1:0] w_product;
  logic [3:0]         w_mul_flags;
  logic               w_start;
  logic               w_capture;

  assign w_a = Y_IN;
  assign w_b = DATA;

  always_comb begin
    w_ext = '0;
    w_res = w_b;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALU_OP)
      ALU_ADD: begin
        w_ext = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      ALU_SUB: begin
        // Top bit of the widened difference is the borrow (A < B unsigned).
        w_ext = {1'b0, w_a} - {1'b0, w_b};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      ALU_NOT:  w_res = ~w_b;
      ALU_SHL: begin
        w_res = {w_a[WIDTH-2:0], 1'b0};
        w_c   = w_a[WIDTH-1];
      end
      ALU_SHR: begin
        w_res = {1'b0, w_a[WIDTH-1:1]};
        w_c   = w_a[0];
      end
      ALU_ASR: begin
        w_res = {w_a[WIDTH-1], w_a[WIDTH-1:1]};
        w_c   = w_a[0];
      end
      ALU_INC: begin
        w_ext = {1'b0, w_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = !w_b[WIDTH-1] && w_res[WIDTH-1];
      end
      ALU_PASS: w_res = w_b;
      default:  w_res = w_b;
    endcase
    w_flags = make_flags(w_res[WIDTH-1], w_res == '0, w_c, w_v);
  end

  // While the multiplier runs, Z_in/ALU_OP are ignored entirely.
  assign w_start   = Z_in && !w_busy && (ALU_OP == ALU_MUL);
  assign w_capture = Z_in && !w_busy && (ALU_OP != ALU_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .i_start   (w_start),
    .i_mcand   (w_a),
    .i_mplier  (w_b),
    .o_busy    (w_busy),
    .o_done    (DONE),
    .o_fin     (w_mul_fin),
    .o_product (w_product)
  );

  assign w_mul_flags = make_flags(w_product[WIDTH-1], w_product[WIDTH-1:0] == '0,
                                  w_product[2*WIDTH-1:WIDTH] != '0, 1'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_z     <= '0;
      r_flags <= '0;
    end else if (w_mul_fin) begin
      r_z     <= w_product[WIDTH-1:0];
      r_flags <= w_mul_flags;
    end else if (w_capture) begin
      r_z     <= w_res;
      r_flags <= w_flags;
    end
  end

  assign DATA      = Z_out ? r_z : {WIDTH{1'bz}};
  assign REG_OUT_Z = r_z;
  assign FLAGS     = r_flags;
  assign BUSY      = w_busy;

endmodule
